spi_frame_controller: RTL and testbench
=======================================

Name: spi_frame_controller

Overview:
- SPI-clock-domain frame sequencer for the host configuration port.
- Decodes each chip-select frame into a command byte plus one or more 32-bit data words.
- Writes go out as a stable address/data pair with a toggle request, so the core-clock config register file can pick them up across the clock-domain crossing.
- Reads fetch a word from the register file and shift it out on MISO. Single and auto-increment burst accesses are supported, and aborted frames are counted.

Parameters:
ADDR_W, 6, register address width (command byte bits 5:0)
NUM_REGS, 6, number of implemented registers; addresses >= NUM_REGS are illegal
ILLEGAL_RD, 32'hDEAD_BEEF, value returned when reading an illegal address

Ports:
spi_sclk  input  1  SPI clock; all state advances on its rising edge
rst_n  input  1  reset, asynchronous, active-low
spi_cs_n  input  1  chip select, active-low; high asynchronously clears frame state
spi_mosi  input  1  serial data in, MSB first, sampled on rising spi_sclk
spi_miso  output  1  serial data out, MSB first, updated on rising spi_sclk
rd_addr  output  ADDR_W  read address to register file (registered)
rd_data  input  32  register file read data, combinational from rd_addr
wr_addr  output  ADDR_W  write address, stable until next write
wr_data  output  32  write data, stable until next write
wr_toggle  output  1  flips once per accepted write (CDC request)
frame_err_cnt  output  8  saturating count of aborted frames
busy  output  1  high when spi_cs_n low and state != IDLE

Behaviour:
- Reset (rst_n low, async) sets the following:
  - state = IDLE, bit counter = 0, mid flag = 0.
  - spi_miso, rd_addr, wr_addr, wr_data, wr_toggle and frame_err_cnt all = 0.
- spi_cs_n high (async):
  - Forces state = IDLE, bit counter = 0, spi_miso = 0.
  - Does NOT clear rd_addr, wr_*, wr_toggle, frame_err_cnt or the mid flag.
- Command byte layout: bit7 = R/W (1 = read), bit6 = burst, bits5:0 = address.
- States: IDLE, CMD, TURN, RDATA, WDATA, DONE. All transitions below occur on rising spi_sclk with spi_cs_n low.
- IDLE:
  - Shift in the first command bit, counter = 1, go to CMD.
  - If mid = 1, increment frame_err_cnt (saturate at 255) and clear mid.
  - Set mid = 1.
- CMD:
  - Shift in one bit per edge.
  - On the 8th command edge, latch the command and reset the counter to 0.
  - Read: set rd_addr = address, go to TURN, clear mid.
  - Write: go to WDATA, clear mid.
- TURN (one edge, reads only):
  - Load the output shifter with rd_data, or with ILLEGAL_RD if rd_addr >= NUM_REGS.
  - Drive spi_miso = bit 31, set mid = 1, go to RDATA.
- RDATA:
  - Edges 1..31 drive spi_miso = bits 30..0 in order.
  - Edge 32 completes the word and clears mid.
  - Burst: rd_addr = rd_addr + 1 (wraps modulo 2^ADDR_W), go to TURN.
  - Otherwise go to DONE.
- WDATA:
  - Shift in 32 bits, MSB first. The first bit sets mid.
  - On the 32nd edge, update wr_addr and wr_data and flip wr_toggle if address < NUM_REGS. If the address is illegal, wr_* and wr_toggle are unchanged.
  - Clear mid.
  - Burst: address increments (wraps) and the block stays in WDATA.
  - Otherwise go to DONE.
- DONE: ignore spi_mosi, spi_miso = 0, no error counting; stay until spi_cs_n rises.
- Read frame timing:
  - 8 command edges + 1 turnaround + 32 data edges.
  - Host samples MISO on falling spi_sclk.
  - Each burst word adds another turnaround edge.
- Write latency: wr_* are valid and wr_toggle has flipped immediately after the 32nd data edge. wr_addr and wr_data are held constant until the next accepted write, so they are CDC-safe.
- Aborts:
  - spi_cs_n rising while mid = 1 (partial command, partial word, or in RDATA) leaves no write performed.
  - The error is counted on the first edge of the next frame.
  - Ending a frame at a word boundary, in TURN, or in DONE is clean.
- The address counter is internal; rd_addr mirrors it only for reads.

Test Plan:
- Write single: cmd 0x02, data 0x0000_0005 → after 40 edges, wr_addr = 2, wr_data = 0x5, wr_toggle 0→1, frame_err_cnt = 0.
- Read single: rd_data model returns 0x1234_5678 for addr 1; cmd 0x81 → MISO bits over edges 9..40 = 0x1234_5678; FSM in DONE at edge 41.
- Burst write: cmd 0x40, words 0xA, 0xB, 0xC → three toggles; final wr_addr = 2, wr_data = 0xC. Illegal burst: cmd 0x45, words 0x1, 0x2 → addr 5 written (0x1); addr 6 illegal, second word dropped, one toggle only.
- Illegal read: cmd 0x89 → MISO shifts 0xDEAD_BEEF. Burst read from 0x3F wraps rd_addr to 0x00.
- Abort: write frame with cs_n raised after 20 data bits → no toggle. Next frame's first edge → frame_err_cnt = 1. 300 aborts → count saturates at 255.
- Async reset asserted mid-WDATA → all outputs 0 and state IDLE immediately. Next full write frame completes normally with no error counted.

Source files
------------

// File: rtl/spi_frame_controller.sv
// SPI-clock-domain frame sequencer: decodes a command byte plus 32-bit words into
// register-file reads shifted out on MISO and toggle-qualified, CDC-stable writes.
module spi_frame_controller #(
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned NUM_REGS   = 6,
   parameter logic [31:0] ILLEGAL_RD = 32'hDEAD_BEEF
) (
   input  logic              spi_sclk,
   input  logic              rst_n,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [31:0]       rd_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              wr_toggle,
   output logic [7:0]        frame_err_cnt,
   output logic              busy
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned CMD_W  = 8;
   localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      TURN  = 3'd2,
      RDATA = 3'd3,
      WDATA = 3'd4,
      DONE  = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                miso_q, miso_d;
   logic                mid_q, mid_d;
   logic [CMD_W-2:0]    cmd_sr_q, cmd_sr_d;
   logic                burst_q, burst_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [WORD_W-1:0]   sh_q, sh_d;
   logic [WORD_W-1:0]   wr_data_q, wr_data_d;
   logic                wr_toggle_q, wr_toggle_d;
   logic [7:0]          err_q, err_d;

   logic [CMD_W-1:0]    cmd_byte_c;
   logic [WORD_W-1:0]   rd_word_c;
   logic                wr_legal_c;
   logic                cmd_last_c;
   logic                word_last_c;

   assign cmd_byte_c  = {cmd_sr_q, spi_mosi};
   assign rd_word_c   = ({1'b0, rd_addr_q} < NUM_REGS_W) ? rd_data : ILLEGAL_RD;
   assign wr_legal_c  = ({1'b0, addr_q} < NUM_REGS_W);
   assign cmd_last_c  = (cnt_q == CNT_W'(CMD_W - 1));
   assign word_last_c = (cnt_q == CNT_W'(WORD_W - 1));

   // State register; chip-select high returns the sequencer to IDLE immediately.
   always_ff @(posedge spi_sclk or negedge rst_n or posedge spi_cs_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else if (spi_cs_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = CMD;
         CMD:     if (cmd_last_c) state_d = cmd_byte_c[7] ? TURN : WDATA;
         TURN:    state_d = RDATA;
         RDATA:   if (word_last_c) state_d = burst_q ? TURN : DONE;
         WDATA:   if (word_last_c) state_d = burst_q ? WDATA : DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values.
   always_comb begin
      cnt_d       = cnt_q;
      miso_d      = miso_q;
      mid_d       = mid_q;
      cmd_sr_d    = cmd_sr_q;
      burst_d     = burst_q;
      addr_d      = addr_q;
      rd_addr_d   = rd_addr_q;
      wr_addr_d   = wr_addr_q;
      sh_d        = sh_q;
      wr_data_d   = wr_data_q;
      wr_toggle_d = wr_toggle_q;
      err_d       = err_q;
      unique case (state_q)
         IDLE: begin
            cmd_sr_d = {cmd_sr_q[CMD_W-3:0], spi_mosi};
            cnt_d    = CNT_W'(1);
            miso_d   = 1'b0;
            mid_d    = 1'b1;
            // A frame left mid-transfer is only charged once the next frame starts.
            if (mid_q && (err_q != 8'hFF)) err_d = err_q + 8'd1;
         end
         CMD: begin
            cmd_sr_d = {cmd_sr_q[CMD_W-3:0], spi_mosi};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cmd_last_c) begin
               cnt_d   = '0;
               mid_d   = 1'b0;
               burst_d = cmd_byte_c[6];
               addr_d  = ADDR_W'(cmd_byte_c[5:0]);
               if (cmd_byte_c[7]) rd_addr_d = ADDR_W'(cmd_byte_c[5:0]);
            end
         end
         TURN: begin
            sh_d   = {rd_word_c[WORD_W-2:0], 1'b0};
            miso_d = rd_word_c[WORD_W-1];
            mid_d  = 1'b1;
            cnt_d  = '0;
         end
         RDATA: begin
            sh_d   = {sh_q[WORD_W-2:0], 1'b0};
            miso_d = sh_q[WORD_W-1];
            cnt_d  = cnt_q + CNT_W'(1);
            if (word_last_c) begin
               miso_d = 1'b0;
               mid_d  = 1'b0;
               if (burst_q) rd_addr_d = rd_addr_q + ADDR_W'(1);
            end
         end
         WDATA: begin
            sh_d  = {sh_q[WORD_W-2:0], spi_mosi};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == '0) mid_d = 1'b1;
            if (word_last_c) begin
               mid_d = 1'b0;
               // Illegal addresses are swallowed so the core side never sees them.
               if (wr_legal_c) begin
                  wr_addr_d   = addr_q;
                  wr_data_d   = {sh_q[WORD_W-2:0], spi_mosi};
                  wr_toggle_d = ~wr_toggle_q;
               end
               if (burst_q) addr_d = addr_q + ADDR_W'(1);
            end
         end
         DONE: begin
            miso_d = 1'b0;
         end
         default: begin
            cnt_d  = '0;
            miso_d = 1'b0;
         end
      endcase
   end

   // Frame-scoped flops, cleared by chip-select high as well as reset.
   always_ff @(posedge spi_sclk or negedge rst_n or posedge spi_cs_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         miso_q <= 1'b0;
      end else if (spi_cs_n) begin
         cnt_q  <= '0;
         miso_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         miso_q <= miso_d;
      end
   end

   // Persistent flops survive chip-select so aborts can be detected and writes held.
   always_ff @(posedge spi_sclk or negedge rst_n) begin
      if (!rst_n) begin
         mid_q       <= 1'b0;
         cmd_sr_q    <= '0;
         burst_q     <= 1'b0;
         addr_q      <= '0;
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         sh_q        <= '0;
         wr_data_q   <= '0;
         wr_toggle_q <= 1'b0;
         err_q       <= '0;
      end else if (!spi_cs_n) begin
         mid_q       <= mid_d;
         cmd_sr_q    <= cmd_sr_d;
         burst_q     <= burst_d;
         addr_q      <= addr_d;
         rd_addr_q   <= rd_addr_d;
         wr_addr_q   <= wr_addr_d;
         sh_q        <= sh_d;
         wr_data_q   <= wr_data_d;
         wr_toggle_q <= wr_toggle_d;
         err_q       <= err_d;
      end
   end

   assign spi_miso      = miso_q;
   assign rd_addr       = rd_addr_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign wr_toggle     = wr_toggle_q;
   assign frame_err_cnt = err_q;
   assign busy          = ~spi_cs_n & (state_q != IDLE);

endmodule

// File: tb/tb_spi_frame_controller.sv
// Scoreboard bench for spi_frame_controller: a frame-level host model predicts
// writes, read words and error counts; a monitor compares them as the DUT presents them.
module tb_spi_frame_controller;

   localparam int unsigned ADDR_W     = 6;
   localparam int unsigned NUM_REGS   = 6;
   localparam logic [31:0] ILLEGAL_RD = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [5:0]  a;
      logic [31:0] d;
   } wr_t;

   logic              spi_sclk = 1'b0;
   logic              rst_n    = 1'b0;
   logic              spi_cs_n = 1'b1;
   logic              spi_mosi = 1'b0;
   logic              spi_miso;
   logic [ADDR_W-1:0] rd_addr;
   logic [31:0]       rd_data;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              wr_toggle;
   logic [7:0]        frame_err_cnt;
   logic              busy;

   logic [31:0] regmem [64];

   int n_tests = 0;
   int n_fail  = 0;

   wr_t         exp_wr_q [$];
   logic [31:0] exp_rd_q [$];
   logic [31:0] act_rd_q [$];
   logic [31:0] tb_words [$];

   logic [7:0]  m_err     = 8'd0;
   bit          m_pending = 1'b0;
   logic [5:0]  m_wr_addr = 6'd0;
   logic [31:0] m_wr_data = 32'd0;
   logic        m_toggle  = 1'b0;
   logic [5:0]  m_rd_addr = 6'd0;

   spi_frame_controller #(
      .ADDR_W     (ADDR_W),
      .NUM_REGS   (NUM_REGS),
      .ILLEGAL_RD (ILLEGAL_RD)
   ) dut (
      .spi_sclk      (spi_sclk),
      .rst_n         (rst_n),
      .spi_cs_n      (spi_cs_n),
      .spi_mosi      (spi_mosi),
      .spi_miso      (spi_miso),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_toggle     (wr_toggle),
      .frame_err_cnt (frame_err_cnt),
      .busy          (busy)
   );

   always #5 spi_sclk = ~spi_sclk;

   // Register file model: garbage on illegal addresses so the DUT must substitute.
   assign rd_data = (32'(rd_addr) < NUM_REGS) ? regmem[rd_addr] : (32'hBAD0_0000 | 32'(rd_addr));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_miso"},   32'(spi_miso),      32'd0);
      chk({tag, "_rdaddr"}, 32'(rd_addr),       32'd0);
      chk({tag, "_wraddr"}, 32'(wr_addr),       32'd0);
      chk({tag, "_wrdata"}, wr_data,            32'd0);
      chk({tag, "_toggle"}, 32'(wr_toggle),     32'd0);
      chk({tag, "_errcnt"}, 32'(frame_err_cnt), 32'd0);
      chk({tag, "_busy"},   32'(busy),          32'd0);
   endtask

   // One SPI clock: entered and left at a falling edge; MISO sampled just after the rising edge.
   task automatic sclk_edge(input logic b, output logic so);
      spi_mosi = b;
      @(posedge spi_sclk);
      #1 so = spi_miso;
      @(negedge spi_sclk);
   endtask

   // Host frame: abort_e > 0 raises chip-select after that many edges (writes only).
   task automatic do_frame(input logic [7:0] cmd, input int nw_in, input int abort_e);
      logic [31:0] words [$];
      logic [31:0] cap;
      logic [5:0]  a;
      logic        so, b;
      wr_t         ent;
      bit          is_rd, burst, aborted;
      int          nw, per, total, edges, dw, d;
      is_rd = cmd[7];
      burst = cmd[6];
      nw    = burst ? nw_in : 1;
      per   = is_rd ? 33 : 32;
      cap   = 32'd0;
      for (int i = 0; i < nw; i++) begin
         if (tb_words.size() > 0) words.push_back(tb_words.pop_front());
         else words.push_back($urandom);
      end
      total   = 8 + nw * per;
      edges   = (abort_e > 0 && !is_rd && abort_e < total) ? abort_e : total;
      dw      = (edges > 8) ? (edges - 8) / per : 0;
      if (dw > nw) dw = nw;
      aborted = (edges > 0 && edges < 8) || (edges > 8 && ((edges - 8) % per) != 0);
      for (int i = 0; i < dw; i++) begin
         a = cmd[5:0] + 6'(i);
         if (is_rd) begin
            exp_rd_q.push_back((32'(a) < NUM_REGS) ? regmem[a] : ILLEGAL_RD);
         end else if (32'(a) < NUM_REGS) begin
            ent.a = a;
            ent.d = words[i];
            exp_wr_q.push_back(ent);
            m_wr_addr = a;
            m_wr_data = words[i];
            m_toggle  = ~m_toggle;
         end
      end
      if (is_rd && edges >= 8) m_rd_addr = cmd[5:0] + (burst ? 6'(dw) : 6'd0);
      if (edges > 0 && m_pending && m_err != 8'hFF) m_err = m_err + 8'd1;

      spi_cs_n = 1'b0;
      for (int k = 0; k < edges; k++) begin
         if (k < 8) b = cmd[7-k];
         else if (!is_rd) b = words[(k-8)/32][31-((k-8)%32)];
         else b = 1'($urandom);
         sclk_edge(b, so);
         if (k == 0) chk("err_cnt", 32'(frame_err_cnt), 32'(m_err));
         if (is_rd && k >= 8) begin
            d = (k - 8) % 33;
            if (d <= 31) cap[31-d] = so;
            if (d == 31) act_rd_q.push_back(cap);
         end
      end
      if (edges > 0) m_pending = aborted;
      if (!burst && edges == total) begin
         sclk_edge(1'($urandom), so);
         chk("done_busy", 32'(busy), 32'd1);
         chk("done_miso", 32'(so), 32'd0);
      end
      spi_cs_n = 1'b1;
      #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_miso", 32'(spi_miso), 32'd0);
      chk("hold_wr_addr", 32'(wr_addr), 32'(m_wr_addr));
      chk("hold_wr_data", wr_data, m_wr_data);
      chk("hold_toggle", 32'(wr_toggle), 32'(m_toggle));
      chk("rd_addr", 32'(rd_addr), 32'(m_rd_addr));
      @(negedge spi_sclk);
   endtask

   // Scoreboard monitor: pops expectations whenever the DUT presents a write or a read word.
   initial begin : monitor
      logic prev_tog;
      wr_t  e;
      prev_tog = 1'b0;
      forever begin
         @(negedge spi_sclk);
         if (!rst_n) begin
            prev_tog = 1'b0;
         end else if (wr_toggle !== prev_tog) begin
            prev_tog = wr_toggle;
            if (exp_wr_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %h data %h expected none", wr_addr, wr_data);
            end else begin
               e = exp_wr_q.pop_front();
               chk("sb_wr_addr", 32'(wr_addr), 32'(e.a));
               chk("sb_wr_data", wr_data, e.d);
            end
         end
         while (act_rd_q.size() > 0) begin
            if (exp_rd_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_read: got %h expected none", act_rd_q.pop_front());
            end else begin
               chk("sb_rd_word", act_rd_q.pop_front(), exp_rd_q.pop_front());
            end
         end
      end
   end

   initial begin : stim
      logic       so;
      logic [7:0] cmd;
      int         nw, ab;
      for (int i = 0; i < 64; i++) regmem[i] = $urandom;
      regmem[1] = 32'h1234_5678;
      repeat (2) @(negedge spi_sclk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge spi_sclk);

      tb_words.push_back(32'h0000_0005);
      do_frame(8'h02, 1, 0);
      chk("single_wr_err", 32'(frame_err_cnt), 32'd0);
      do_frame(8'h81, 1, 0);
      tb_words.push_back(32'hA); tb_words.push_back(32'hB); tb_words.push_back(32'hC);
      do_frame(8'h40, 3, 0);
      tb_words.push_back(32'h1); tb_words.push_back(32'h2);
      do_frame(8'h45, 2, 0);
      do_frame(8'h89, 1, 0);
      do_frame(8'hFF, 2, 0);

      // Abort after 20 data bits, then a clean frame carries the error count.
      do_frame(8'h03, 1, 28);
      do_frame(8'h04, 1, 0);
      for (int i = 0; i < 300; i++) do_frame(8'h00, 1, 3);
      do_frame(8'h01, 1, 0);
      chk("sat_err", 32'(frame_err_cnt), 32'd255);

      // Asynchronous reset in the middle of a write word.
      spi_cs_n = 1'b0;
      for (int k = 0; k < 18; k++) sclk_edge((k < 8) ? ((8'h03 >> (7 - k)) & 8'h01) != 0 : 1'($urandom), so);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      m_err = 8'd0; m_pending = 1'b0; m_toggle = 1'b0;
      m_wr_addr = 6'd0; m_wr_data = 32'd0; m_rd_addr = 6'd0;
      @(negedge spi_sclk);
      spi_cs_n = 1'b1;
      rst_n    = 1'b1;
      @(negedge spi_sclk);
      do_frame(8'h03, 1, 0);

      for (int t = 0; t < 40; t++) begin
         cmd = 8'($urandom);
         if ($urandom_range(0, 1) == 1) cmd[5:0] = 6'($urandom_range(0, 7));
         nw = cmd[6] ? int'($urandom_range(1, 3)) : 1;
         ab = (!cmd[7] && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8 + 32 * nw - 1)) : 0;
         do_frame(cmd, nw, ab);
      end

      repeat (3) @(negedge spi_sclk);
      chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
      chk("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
